// File: rtl/llsc_reservation_ctrl.sv
// LL/SC reservation tracker for the MEM stage: holds the link flag, linked granule and
// link lifetime timer, and resolves SC success combinationally in the cycle it commits.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  S_IDLE   | no reservation held; any SC fails; timer parked at 0
//  S_LINKED | reservation held on link_addr_q's granule; timer running
module llsc_reservation_ctrl #(
    parameter int GRAN_LOG2    = 2,
    parameter int LINK_TIMEOUT = 1024,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        eret_i,
    input  logic        stall_i,
    input  logic        mem_ll_i,
    input  logic        mem_sc_i,
    input  logic [31:0] mem_addr_i,
    input  logic        snoop_we_i,
    input  logic [31:0] snoop_addr_i,
    output logic        sc_pass_o,
    output logic        sc_store_en_o,
    output logic [31:0] sc_result_o,
    output logic        llbit_o,
    output logic [31:0] link_addr_o
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LINKED = 1'b1
    } state_t;

    localparam logic [31:0]      GRAN_MASK  = ~((32'd1 << GRAN_LOG2) - 32'd1);
    localparam bit               TIMEOUT_EN = (LINK_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TMO_LOAD   = CNT_W'(LINK_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [31:0]      link_addr_q, link_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic linked;
    logic ll_go;
    logic sc_go;
    logic snoop_hit;
    logic snoop_ll;
    logic sc_addr_match;
    logic timed_out;

    // The timer counts down from LINK_TIMEOUT-1 after arming; reaching zero in LINKED
    // means the reservation has been held for exactly LINK_TIMEOUT cycles.
    always_comb begin
        linked        = (state_q == S_LINKED);
        ll_go         = mem_ll_i & ~stall_i & ~flush;
        sc_go         = mem_sc_i & ~stall_i & ~flush;
        snoop_hit     = snoop_we_i & linked &
                        ((snoop_addr_i & GRAN_MASK) == (link_addr_q & GRAN_MASK));
        snoop_ll      = snoop_we_i &
                        ((snoop_addr_i & GRAN_MASK) == (mem_addr_i & GRAN_MASK));
        sc_addr_match = ((mem_addr_i & GRAN_MASK) == (link_addr_q & GRAN_MASK));
        timed_out     = linked & TIMEOUT_EN & (cnt_q == '0);

        sc_pass_o     = sc_go & linked & ~snoop_hit & sc_addr_match;
        sc_store_en_o = sc_pass_o;
        sc_result_o   = {31'b0, sc_pass_o};
        llbit_o       = linked;
        link_addr_o   = link_addr_q;
    end

    always_comb begin
        state_d     = state_q;
        link_addr_d = link_addr_q;
        cnt_d       = cnt_q;

        if (flush) begin
            state_d = S_IDLE;
        end else if (eret_i && !stall_i) begin
            state_d = S_IDLE;
        end else if (ll_go && !snoop_ll) begin
            state_d     = S_LINKED;
            link_addr_d = mem_addr_i & GRAN_MASK;
            cnt_d       = TIMEOUT_EN ? TMO_LOAD : '0;
        end else if (ll_go) begin
            state_d = S_IDLE;
        end else if (sc_go) begin
            state_d = S_IDLE;
        end else if (snoop_hit) begin
            state_d = S_IDLE;
        end else if (timed_out) begin
            state_d = S_IDLE;
        end else if (linked && TIMEOUT_EN) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // Link address survives a drop; only the timer is parked.
        if (state_d == S_IDLE) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            link_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            link_addr_q <= link_addr_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_llsc_reservation_ctrl.sv
// Bench for llsc_reservation_ctrl: directed vector table, timeout/re-arm sequences,
// then randomized traffic compared against a reservation model.
module tb_llsc_reservation_ctrl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst, flush, eret_i, stall_i, mem_ll_i, mem_sc_i, snoop_we_i;
    logic [31:0] mem_addr_i, snoop_addr_i;
    logic        sc_pass_o, sc_store_en_o, llbit_o;
    logic [31:0] sc_result_o, link_addr_o;

    int checks = 0;
    int failures = 0;

    llsc_reservation_ctrl #(.GRAN_LOG2(2), .LINK_TIMEOUT(T), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .eret_i(eret_i), .stall_i(stall_i),
        .mem_ll_i(mem_ll_i), .mem_sc_i(mem_sc_i), .mem_addr_i(mem_addr_i),
        .snoop_we_i(snoop_we_i), .snoop_addr_i(snoop_addr_i),
        .sc_pass_o(sc_pass_o), .sc_store_en_o(sc_store_en_o), .sc_result_o(sc_result_o),
        .llbit_o(llbit_o), .link_addr_o(link_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, flush, eret, stall, ll, sc;
        logic [31:0] addr;
        logic        swe;
        logic [31:0] saddr;
        logic        exp_pass, exp_llbit;
        logic [31:0] exp_laddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, f, e, s, l, c, input logic [31:0] a,
                               input logic w, input logic [31:0] sa,
                               input logic p, lb, input logic [31:0] la);
        vec_t t;
        t.rst = r; t.flush = f; t.eret = e; t.stall = s; t.ll = l; t.sc = c;
        t.addr = a; t.swe = w; t.saddr = sa;
        t.exp_pass = p; t.exp_llbit = lb; t.exp_laddr = la;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs, sample mid-cycle, then step past the next edge.
    task automatic apply(input vec_t t, input string tag);
        rst = t.rst; flush = t.flush; eret_i = t.eret; stall_i = t.stall;
        mem_ll_i = t.ll; mem_sc_i = t.sc; mem_addr_i = t.addr;
        snoop_we_i = t.swe; snoop_addr_i = t.saddr;
        #2;
        chk({tag, " sc_pass"}, {31'b0, sc_pass_o}, {31'b0, t.exp_pass});
        chk({tag, " store_en"}, {31'b0, sc_store_en_o}, {31'b0, t.exp_pass});
        chk({tag, " result"}, sc_result_o, {31'b0, t.exp_pass});
        chk({tag, " llbit"}, {31'b0, llbit_o}, {31'b0, t.exp_llbit});
        chk({tag, " link_addr"}, link_addr_o, t.exp_laddr);
        @(posedge clk);
        #1;
    endtask

    // Reservation model: granule number, cycles held since arming, priority of events.
    logic        m_linked;
    logic [31:0] m_addr;
    int          m_age;

    function automatic logic [29:0] gran(input logic [31:0] a);
        return a[31:2];
    endfunction

    function automatic logic model_pass(input vec_t t);
        logic hit;
        hit = t.swe && m_linked && gran(t.saddr) == gran(m_addr);
        return t.sc && !t.stall && !t.flush && m_linked && !hit &&
               gran(t.addr) == gran(m_addr);
    endfunction

    task automatic model_step(input vec_t t);
        logic hit;
        hit = t.swe && m_linked && gran(t.saddr) == gran(m_addr);
        if (t.rst) begin
            m_linked = 1'b0; m_addr = 32'h0; m_age = 0;
        end else if (t.flush || (t.eret && !t.stall)) begin
            m_linked = 1'b0;
        end else if (t.ll && !t.stall) begin
            if (t.swe && gran(t.saddr) == gran(t.addr)) begin
                m_linked = 1'b0;
            end else begin
                m_linked = 1'b1; m_addr = {t.addr[31:2], 2'b00}; m_age = 0;
            end
        end else if ((t.sc && !t.stall) || hit || (m_linked && m_age == T - 1)) begin
            m_linked = 1'b0;
        end else if (m_linked) begin
            m_age++;
        end
    endtask

    initial begin
        logic [31:0] pool [4];
        vec_t t;
        pool[0] = 32'h1000; pool[1] = 32'h1003; pool[2] = 32'h1004; pool[3] = 32'h2000;

        //           rst f e s ll sc addr          swe saddr        pass llb laddr
        vecs.push_back(v(1, 0,0,0,0,0, 32'h0,      0, 32'h0,      0,0, 32'h0));
        vecs.push_back(v(0, 0,0,0,1,0, 32'h1000,   0, 32'h0,      0,0, 32'h0));
        vecs.push_back(v(0, 0,0,0,0,0, 32'h0,      0, 32'h0,      0,1, 32'h1000));
        vecs.push_back(v(0, 0,0,0,0,1, 32'h1000,   0, 32'h0,      1,1, 32'h1000));
        vecs.push_back(v(0, 0,0,0,0,0, 32'h0,      0, 32'h0,      0,0, 32'h1000));
        vecs.push_back(v(0, 0,0,0,1,0, 32'h1000,   0, 32'h0,      0,0, 32'h1000));
        vecs.push_back(v(0, 0,0,0,0,0, 32'h0,      1, 32'h1002,   0,1, 32'h1000));
        vecs.push_back(v(0, 0,0,0,0,1, 32'h1000,   0, 32'h0,      0,0, 32'h1000));
        vecs.push_back(v(0, 0,0,0,1,0, 32'h1000,   0, 32'h0,      0,0, 32'h1000));
        vecs.push_back(v(0, 0,0,0,0,1, 32'h2000,   0, 32'h0,      0,1, 32'h1000));
        vecs.push_back(v(0, 0,0,0,0,1, 32'h1000,   0, 32'h0,      0,0, 32'h1000));
        vecs.push_back(v(0, 1,0,0,1,0, 32'h1000,   0, 32'h0,      0,0, 32'h1000));
        vecs.push_back(v(0, 0,0,0,0,1, 32'h1000,   0, 32'h0,      0,0, 32'h1000));
        vecs.push_back(v(0, 0,0,0,1,0, 32'h1004,   0, 32'h0,      0,0, 32'h1000));
        vecs.push_back(v(0, 0,0,1,0,1, 32'h1004,   0, 32'h0,      0,1, 32'h1004));
        vecs.push_back(v(0, 0,0,0,0,1, 32'h1004,   0, 32'h0,      1,1, 32'h1004));
        vecs.push_back(v(0, 0,0,0,0,0, 32'h0,      0, 32'h0,      0,0, 32'h1004));
        vecs.push_back(v(0, 0,0,0,1,0, 32'h3000,   1, 32'h3000,   0,0, 32'h1004));
        vecs.push_back(v(0, 0,0,0,0,1, 32'h3000,   0, 32'h0,      0,0, 32'h1004));
        vecs.push_back(v(0, 0,0,0,1,0, 32'h1000,   0, 32'h0,      0,0, 32'h1004));
        vecs.push_back(v(0, 0,1,1,0,0, 32'h0,      0, 32'h0,      0,1, 32'h1000));
        vecs.push_back(v(0, 0,1,0,0,0, 32'h0,      0, 32'h0,      0,1, 32'h1000));
        vecs.push_back(v(0, 0,0,0,0,1, 32'h1000,   0, 32'h0,      0,0, 32'h1000));
        vecs.push_back(v(0, 0,0,0,1,0, 32'h1000,   0, 32'h0,      0,0, 32'h1000));
        vecs.push_back(v(0, 0,0,0,0,0, 32'h0,      1, 32'h2000,   0,1, 32'h1000));
        vecs.push_back(v(0, 1,0,0,0,1, 32'h1000,   0, 32'h0,      0,1, 32'h1000));
        vecs.push_back(v(0, 0,0,0,0,1, 32'h1000,   0, 32'h0,      0,0, 32'h1000));
        vecs.push_back(v(0, 0,0,0,1,0, 32'h5000,   0, 32'h0,      0,0, 32'h1000));
        vecs.push_back(v(1, 0,0,0,0,0, 32'h0,      0, 32'h0,      0,1, 32'h5000));
        vecs.push_back(v(0, 0,0,0,0,0, 32'h0,      0, 32'h0,      0,0, 32'h0));
        vecs.push_back(v(0, 0,0,0,0,0, 32'h0,      1, 32'h0,      0,0, 32'h0));

        rst = 1'b1; flush = 0; eret_i = 0; stall_i = 0; mem_ll_i = 0; mem_sc_i = 0;
        mem_addr_i = 0; snoop_we_i = 0; snoop_addr_i = 0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Timeout: held for exactly T cycles, then dropped; SC afterwards fails.
        apply(v(0, 0,0,0,1,0, 32'h7000, 0, 32'h0, 0,0, 32'h0), "tmo_ll");
        for (int k = 0; k < T; k++)
            apply(v(0, 0,0,0,0,0, 32'h0, 0, 32'h0, 0,1, 32'h7000), $sformatf("tmo_hold%0d", k));
        apply(v(0, 0,0,0,0,0, 32'h0, 0, 32'h0, 0,0, 32'h7000), "tmo_drop");
        apply(v(0, 0,0,0,0,1, 32'h7000, 0, 32'h0, 0,0, 32'h7000), "tmo_sc");

        // Re-arm restarts the timer: a second LL after 5 cycles gives T more linked cycles.
        apply(v(0, 0,0,0,1,0, 32'h8000, 0, 32'h0, 0,0, 32'h7000), "rearm_ll1");
        for (int k = 0; k < 5; k++)
            apply(v(0, 0,0,0,0,0, 32'h0, 0, 32'h0, 0,1, 32'h8000), $sformatf("rearm_a%0d", k));
        apply(v(0, 0,0,0,1,0, 32'h9000, 0, 32'h0, 0,1, 32'h8000), "rearm_ll2");
        for (int k = 0; k < T - 1; k++)
            apply(v(0, 0,0,0,0,0, 32'h0, 0, 32'h0, 0,1, 32'h9000), $sformatf("rearm_b%0d", k));
        apply(v(0, 0,0,0,0,1, 32'h9000, 0, 32'h0, 1,1, 32'h9000), "rearm_sc_last");
        apply(v(0, 0,0,0,0,0, 32'h0, 0, 32'h0, 0,0, 32'h9000), "rearm_done");

        // Randomized traffic against the model, starting from a fresh reset.
        m_linked = 1'b0; m_addr = 32'h0; m_age = 0;
        t = v(1, 0,0,0,0,0, 32'h0, 0, 32'h0, 0,0, 32'h0);
        t.exp_llbit = llbit_o === 1'b1 ? 1'b1 : 1'b0;
        t.exp_llbit = 1'b0;
        t.exp_laddr = 32'h9000;
        apply(t, "rnd_reset");
        model_step(t);
        for (int i = 0; i < 3000; i++) begin
            int op;
            op = int'($urandom_range(0, 3));
            t.rst   = ($urandom_range(0, 199) == 0);
            t.flush = ($urandom_range(0, 11) == 0);
            t.eret  = ($urandom_range(0, 14) == 0);
            t.stall = ($urandom_range(0, 4) == 0);
            t.ll    = (op == 0);
            t.sc    = (op == 1);
            t.addr  = pool[$urandom_range(0, 3)];
            t.swe   = ($urandom_range(0, 3) == 0);
            t.saddr = pool[$urandom_range(0, 3)];
            t.exp_pass  = model_pass(t);
            t.exp_llbit = m_linked;
            t.exp_laddr = m_addr;
            apply(t, $sformatf("rnd%0d", i));
            model_step(t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
